// File: rtl/exec_alu_pkg.sv
// Shared constants for the execute-stage ALU: widths, gout codes, ALU-op and funct encodings.
package exec_alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned GOUT_W  = 3;
    localparam int unsigned FUNCT_W = 4;

    // ALU operation codes driven on gout
    localparam logic [GOUT_W-1:0] ALU_AND = 3'b000;
    localparam logic [GOUT_W-1:0] ALU_OR  = 3'b001;
    localparam logic [GOUT_W-1:0] ALU_ADD = 3'b010;
    localparam logic [GOUT_W-1:0] ALU_NOR = 3'b011;
    localparam logic [GOUT_W-1:0] ALU_XOR = 3'b100;
    localparam logic [GOUT_W-1:0] ALU_SUB = 3'b110;
    localparam logic [GOUT_W-1:0] ALU_SLT = 3'b111;

    // Main-control ALU-op encodings {aluop1, aluop0}
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // R-type funct[3:0] values
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 4'b0000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 4'b0010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 4'b0100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 4'b0101;
    localparam logic [FUNCT_W-1:0] FUNCT_XOR = 4'b0110;
    localparam logic [FUNCT_W-1:0] FUNCT_NOR = 4'b0111;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 4'b1010;

endpackage

// File: rtl/exec_alu_if.sv
// Operand/control bundle into the execute stage and its result/status bundle out.
interface exec_alu_if;
    import exec_alu_pkg::*;

    logic                  aluop1;
    logic                  aluop0;
    logic [FUNCT_W-1:0]    funct;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     sext_imm;
    logic                  flag_we;

    logic [GOUT_W-1:0]     gout;
    logic [DATA_W-1:0]     sum;
    logic                  zout;
    logic [DATA_W-1:0]     pc_plus4;
    logic [DATA_W-1:0]     br_target;
    logic                  n_flag;
    logic                  v_flag;
    logic                  z_flag;

    // Decode/regfile side drives operands and observes results
    modport master (
        output aluop1, aluop0, funct, a, b, pc, sext_imm, flag_we,
        input  gout, sum, zout, pc_plus4, br_target, n_flag, v_flag, z_flag
    );

    // Execute unit side
    modport slave (
        input  aluop1, aluop0, funct, a, b, pc, sext_imm, flag_we,
        output gout, sum, zout, pc_plus4, br_target, n_flag, v_flag, z_flag
    );
endinterface

// File: rtl/exec_alu_ctrl.sv
// ALU-control decode: {aluop1, aluop0, funct} -> gout. Purely combinational.
// Optional NOR/XOR R-type decode is enabled by defining EXEC_LOGIC_EXT_EN.
module exec_alu_ctrl
    import exec_alu_pkg::*;
(
    input  logic               aluop1,
    input  logic               aluop0,
    input  logic [FUNCT_W-1:0] funct,
    output logic [GOUT_W-1:0]  gout
);

    // aluop0 takes priority so 01 and 11 both mean SUB (branch compare)
    always_comb begin
        gout = ALU_ADD;
        if (aluop0) begin
            gout = ALU_SUB;
        end else if (aluop1) begin
            case (funct)
                FUNCT_ADD: gout = ALU_ADD;
                FUNCT_SUB: gout = ALU_SUB;
                FUNCT_AND: gout = ALU_AND;
                FUNCT_OR:  gout = ALU_OR;
                FUNCT_SLT: gout = ALU_SLT;
`ifdef EXEC_LOGIC_EXT_EN
                FUNCT_NOR: gout = ALU_NOR;
                FUNCT_XOR: gout = ALU_XOR;
`endif
                default:   gout = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/exec_alu_unit.sv
// Execute-stage datapath: ALU-control decode, 32-bit ALU, PC+4 and branch-target
// adders, and a registered N/V/Z status register for flag branches.
// Optional feature macro: EXEC_LOGIC_EXT_EN (adds R-type NOR/XOR).
module exec_alu_unit
    import exec_alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    exec_alu_if.slave      bus
);

    logic [GOUT_W-1:0] gout_w;
    logic [DATA_W-1:0] add_res;
    logic [DATA_W-1:0] sub_res;
    logic              slt_lt;
    logic [DATA_W-1:0] alu_res;
    logic              ovf;
    logic              zero;
    logic              n_q;
    logic              v_q;
    logic              z_q;

    exec_alu_ctrl u_ctrl (
        .aluop1 (bus.aluop1),
        .aluop0 (bus.aluop0),
        .funct  (bus.funct),
        .gout   (gout_w)
    );

    // ALU core: result select, signed less-than and overflow detection
    always_comb begin
        add_res = bus.a + bus.b;
        sub_res = bus.a - bus.b;
        slt_lt  = (bus.a[DATA_W-1] != bus.b[DATA_W-1]) ? bus.a[DATA_W-1] : sub_res[DATA_W-1];
        alu_res = '0;
        ovf     = 1'b0;
        case (gout_w)
            ALU_AND: alu_res = bus.a & bus.b;
            ALU_OR:  alu_res = bus.a | bus.b;
            ALU_ADD: begin
                alu_res = add_res;
                ovf     = (bus.a[DATA_W-1] == bus.b[DATA_W-1]) &&
                          (add_res[DATA_W-1] != bus.a[DATA_W-1]);
            end
            ALU_NOR: alu_res = ~(bus.a | bus.b);
            ALU_XOR: alu_res = bus.a ^ bus.b;
            ALU_SUB: begin
                alu_res = sub_res;
                ovf     = (bus.a[DATA_W-1] != bus.b[DATA_W-1]) &&
                          (sub_res[DATA_W-1] != bus.a[DATA_W-1]);
            end
            ALU_SLT: alu_res = DATA_W'(slt_lt);
            default: alu_res = '0;
        endcase
        zero = ~|alu_res;
    end

    // Status register: capture N/V/Z on enabled edges, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q <= 1'b0;
            v_q <= 1'b0;
            z_q <= 1'b0;
        end else if (bus.flag_we) begin
            n_q <= alu_res[DATA_W-1];
            v_q <= ovf;
            z_q <= zero;
        end
    end

    // Branch offset is a word offset; upper two immediate bits fall off the shift
    assign bus.pc_plus4  = bus.pc + DATA_W'(4);
    assign bus.br_target = bus.pc_plus4 + DATA_W'(bus.sext_imm << 2);

    assign bus.gout   = gout_w;
    assign bus.sum    = alu_res;
    assign bus.zout   = zero;
    assign bus.n_flag = n_q;
    assign bus.v_flag = v_q;
    assign bus.z_flag = z_q;

endmodule

// File: tb/tb_exec_alu_unit.sv
// Directed self-checking bench for exec_alu_unit.
module tb_exec_alu_unit;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    exec_alu_if bus ();

    exec_alu_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic op1, input logic op0, input logic [3:0] fn,
                          input logic [31:0] av, input logic [31:0] bv);
        bus.aluop1 = op1;
        bus.aluop0 = op0;
        bus.funct  = fn;
        bus.a      = av;
        bus.b      = bv;
    endtask

    task automatic check_flags(input string tag, input logic n, input logic v, input logic z);
        check({tag, "_n"}, 32'(bus.n_flag), 32'(n));
        check({tag, "_v"}, 32'(bus.v_flag), 32'(v));
        check({tag, "_z"}, 32'(bus.z_flag), 32'(z));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.flag_we  = 1'b0;
        bus.pc       = 32'h0;
        bus.sext_imm = 32'h0;
        set_op(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        #1;
        check_flags("reset", 1'b0, 1'b0, 1'b0);

        // ADD overflow via R-type funct 0000
        @(negedge clk);
        rst_n = 1'b1;
        set_op(1'b1, 1'b0, 4'b0000, 32'h7FFFFFFF, 32'h1);
        bus.flag_we = 1'b1;
        #1;
        check("add_gout", 32'(bus.gout), 32'h2);
        check("add_sum", bus.sum, 32'h80000000);
        check("add_zout", 32'(bus.zout), 32'h0);
        @(posedge clk); #1;
        check_flags("add_ovf", 1'b1, 1'b1, 1'b0);

        // SUB equal, first with flag_we low (hold), then high
        @(negedge clk);
        set_op(1'b0, 1'b1, 4'b1111, 32'h5, 32'h5);
        bus.flag_we = 1'b0;
        #1;
        check("sub_gout", 32'(bus.gout), 32'h6);
        check("sub_sum", bus.sum, 32'h0);
        check("sub_zout", 32'(bus.zout), 32'h1);
        @(posedge clk); #1;
        check_flags("hold", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        bus.flag_we = 1'b1;
        @(posedge clk); #1;
        check_flags("sub_eq", 1'b0, 1'b0, 1'b1);

        // SUB overflow, with aluop=11 (aluop0 wins)
        @(negedge clk);
        set_op(1'b1, 1'b1, 4'b0100, 32'h80000000, 32'h1);
        #1;
        check("sub11_gout", 32'(bus.gout), 32'h6);
        check("sub_ovf_sum", bus.sum, 32'h7FFFFFFF);
        @(posedge clk); #1;
        check_flags("sub_ovf", 1'b0, 1'b1, 1'b0);

        // SLT signed cases
        @(negedge clk);
        bus.flag_we = 1'b0;
        set_op(1'b1, 1'b0, 4'b1010, 32'hFFFFFFFF, 32'h1);
        #1;
        check("slt_gout", 32'(bus.gout), 32'h7);
        check("slt_neg1_lt_1", bus.sum, 32'h1);
        bus.a = 32'h1; bus.b = 32'hFFFFFFFF; #1;
        check("slt_1_lt_neg1", bus.sum, 32'h0);
        check("slt_zout", 32'(bus.zout), 32'h1);
        bus.a = 32'h80000000; bus.b = 32'h1; #1;
        check("slt_min_lt_1", bus.sum, 32'h1);
        bus.a = 32'h3; bus.b = 32'h7; #1;
        check("slt_3_lt_7", bus.sum, 32'h1);

        // Logic ops, R-type SUB and unlisted funct
        set_op(1'b1, 1'b0, 4'b0100, 32'hF0F0_1234, 32'hFF00_00FF); #1;
        check("and_gout", 32'(bus.gout), 32'h0);
        check("and_sum", bus.sum, 32'hF000_0034);
        set_op(1'b1, 1'b0, 4'b0101, 32'hF0F0_1234, 32'hFF00_00FF); #1;
        check("or_gout", 32'(bus.gout), 32'h1);
        check("or_sum", bus.sum, 32'hFFF0_12FF);
        set_op(1'b1, 1'b0, 4'b0010, 32'h10, 32'h20); #1;
        check("rsub_sum", bus.sum, 32'hFFFFFFF0);
        set_op(1'b1, 1'b0, 4'b1111, 32'hFFFFFFFF, 32'h1); #1;
        check("unlisted_gout", 32'(bus.gout), 32'h2);
        check("unlisted_sum", bus.sum, 32'h0);
        set_op(1'b0, 1'b0, 4'b0100, 32'h12, 32'h30); #1;
        check("aluop00_sum", bus.sum, 32'h42);

        // Optional NOR/XOR decode
        set_op(1'b1, 1'b0, 4'b0111, 32'h0F0F0F0F, 32'h00FF00FF); #1;
`ifdef EXEC_LOGIC_EXT_EN
        check("f0111_gout", 32'(bus.gout), 32'h3);
        check("f0111_sum", bus.sum, 32'hF000F000);
`else
        check("f0111_gout", 32'(bus.gout), 32'h2);
        check("f0111_sum", bus.sum, 32'h100E100E);
`endif
        bus.funct = 4'b0110; #1;
`ifdef EXEC_LOGIC_EXT_EN
        check("f0110_sum", bus.sum, 32'h0FF00FF0);
`else
        check("f0110_sum", bus.sum, 32'h100E100E);
`endif

        // PC adders
        bus.pc = 32'h0000001C; bus.sext_imm = 32'hFFFFFFFE; #1;
        check("pc_plus4", bus.pc_plus4, 32'h00000020);
        check("br_back", bus.br_target, 32'h00000018);
        bus.pc = 32'hFFFFFFFC; bus.sext_imm = 32'h40000001; #1;
        check("pc_wrap", bus.pc_plus4, 32'h0);
        check("br_imm_top", bus.br_target, 32'h00000004);

        // Asynchronous reset mid-cycle overrides flag_we
        @(negedge clk);
        set_op(1'b1, 1'b0, 4'b0000, 32'h7FFFFFFF, 32'h1);
        bus.flag_we = 1'b1;
        @(posedge clk); #1;
        check_flags("pre_rst", 1'b1, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_flags("async_rst", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_flags("rst_we", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_flags("deassert", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_flags("post_rst", 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
